// File: rtl/pc_call_sequencer_if.sv
// Decode/stack-facing bundle of the PC call sequencer. The master modport is the sequencer;
// the slave modport is the decode + return-stack side.
interface pc_call_sequencer_if #(
    parameter int unsigned PC_W = 12
);
    logic            instr_valid_i;
    logic [2:0]      op_i;
    logic            cond_i;
    logic [PC_W-1:0] target_i;
    logic            int_req_i;
    logic            int_ack_o;
    logic            int_en_o;
    logic            stk_push_o;
    logic            stk_pop_o;
    logic [PC_W-1:0] stk_pc_o;
    logic [PC_W-1:0] stk_pc_i;
    logic [PC_W-1:0] pc_o;
    logic            busy_o;
    logic [3:0]      depth_o;
    logic            ovf_o;
    logic            unf_o;

    modport master (
        input  instr_valid_i, op_i, cond_i, target_i, int_req_i, stk_pc_i,
        output int_ack_o, int_en_o, stk_push_o, stk_pop_o, stk_pc_o, pc_o, busy_o, depth_o,
               ovf_o, unf_o
    );

    modport slave (
        output instr_valid_i, op_i, cond_i, target_i, int_req_i, stk_pc_i,
        input  int_ack_o, int_en_o, stk_push_o, stk_pop_o, stk_pc_o, pc_o, busy_o, depth_o,
               ovf_o, unf_o
    );
endinterface

// File: rtl/pc_call_sequencer.sv
// Program-counter sequencer: resolves flow-control ops and interrupts, drives the return stack
// strobes and shadows its depth to flag overflow/underflow.
module pc_call_sequencer #(
    parameter int unsigned    PC_W     = 12,
    parameter int unsigned    DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] INT_VEC  = PC_W'(1)
) (
    input  logic                   stkClk,
    input  logic                   rst,
    pc_call_sequencer_if.master    bus
);
    localparam logic [2:0] OpSeq  = 3'd0;
    localparam logic [2:0] OpJmp  = 3'd1;
    localparam logic [2:0] OpBr   = 3'd2;
    localparam logic [2:0] OpJsb  = 3'd3;
    localparam logic [2:0] OpRet  = 3'd4;
    localparam logic [2:0] OpReti = 3'd5;
    localparam logic [2:0] OpEnai = 3'd6;
    localparam logic [2:0] OpDisi = 3'd7;
    localparam logic [3:0] DepthMax = 4'(DEPTH);

    typedef enum logic [0:0] {StRun, StRetWait} state_e;

    state_e          state;
    logic [PC_W-1:0] pc;
    logic [3:0]      depth;
    logic            int_en;
    logic            ovf;
    logic            unf;
    logic            reti_pend;

    logic            take_int;
    logic            dec_valid;
    logic            is_ret;
    logic            do_push;
    logic            do_pop;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc    = pc + PC_W'(1);
    assign take_int  = (state == StRun) && bus.int_req_i && int_en;
    assign dec_valid = (state == StRun) && !take_int && bus.instr_valid_i;
    assign is_ret    = (bus.op_i == OpRet) || (bus.op_i == OpReti);
    assign do_push   = !rst && (take_int || (dec_valid && bus.op_i == OpJsb));
    assign do_pop    = !rst && dec_valid && is_ret && (depth != 4'd0);

    assign bus.stk_push_o = do_push;
    assign bus.stk_pop_o  = do_pop;
    // An interrupt saves the unexecuted instruction's address; a call saves the next one.
    assign bus.stk_pc_o   = take_int ? pc : pc_inc;
    assign bus.int_ack_o  = !rst && take_int;
    assign bus.int_en_o   = int_en;
    assign bus.pc_o       = pc;
    assign bus.busy_o     = (state == StRetWait);
    assign bus.depth_o    = depth;
    assign bus.ovf_o      = ovf;
    assign bus.unf_o      = unf;

    always_ff @(posedge stkClk or posedge rst) begin
        if (rst) begin
            state     <= StRun;
            pc        <= RESET_PC;
            depth     <= 4'd0;
            int_en    <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            reti_pend <= 1'b0;
        end else begin
            // Stack wraps on push when full; depth saturates so later pops stay bounded.
            if (do_push) begin
                if (depth == DepthMax) ovf <= 1'b1;
                else                   depth <= depth + 4'd1;
            end
            unique case (state)
                StRun: begin
                    if (take_int) begin
                        pc     <= INT_VEC;
                        int_en <= 1'b0;
                    end else if (bus.instr_valid_i) begin
                        case (bus.op_i)
                            OpSeq:  pc <= pc_inc;
                            OpJmp:  pc <= bus.target_i;
                            OpBr:   pc <= bus.cond_i ? bus.target_i : pc_inc;
                            OpJsb:  pc <= bus.target_i;
                            OpRet, OpReti: begin
                                if (depth != 4'd0) begin
                                    depth     <= depth - 4'd1;
                                    reti_pend <= (bus.op_i == OpReti);
                                    state     <= StRetWait;
                                end else begin
                                    unf <= 1'b1;
                                    pc  <= pc_inc;
                                end
                            end
                            OpEnai: begin
                                int_en <= 1'b1;
                                pc     <= pc_inc;
                            end
                            OpDisi: begin
                                int_en <= 1'b0;
                                pc     <= pc_inc;
                            end
                        endcase
                    end
                end
                StRetWait: begin
                    pc    <= bus.stk_pc_i;
                    state <= StRun;
                    if (reti_pend) int_en <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_call_sequencer.sv
// Directed bench for pc_call_sequencer: drives decode/stack signals by hand and checks
// registered state after each edge and combinational strobes before it.
module tb_pc_call_sequencer;
    logic stkClk = 1'b0;
    logic rst    = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    pc_call_sequencer_if #(.PC_W(12)) bus ();

    pc_call_sequencer dut (
        .stkClk (stkClk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 stkClk = ~stkClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered outputs are checked #1 after the edge; inputs change at the same point.
    task automatic step();
        @(posedge stkClk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] tgt, input logic cond);
        bus.instr_valid_i = 1'b1;
        bus.op_i          = op;
        bus.target_i      = tgt;
        bus.cond_i        = cond;
        #1;
    endtask

    initial begin
        bus.instr_valid_i = 1'b0;
        bus.op_i          = 3'd0;
        bus.cond_i        = 1'b0;
        bus.target_i      = 12'h000;
        bus.int_req_i     = 1'b0;
        bus.stk_pc_i      = 12'h000;
        #12;
        check("rst_pc",    32'(bus.pc_o), 32'h000);
        check("rst_depth", 32'(bus.depth_o), 32'd0);
        check("rst_flags", {28'd0, bus.busy_o, bus.int_en_o, bus.ovf_o, bus.unf_o}, 32'd0);
        check("rst_strb",  {29'd0, bus.stk_push_o, bus.stk_pop_o, bus.int_ack_o}, 32'd0);
        rst = 1'b0;
        step();

        // Sequential and branch flow, including wrap at FFF
        drive(3'd1, 12'hFFF, 1'b0); step();
        check("jmp_fff", 32'(bus.pc_o), 32'hFFF);
        drive(3'd0, 12'h000, 1'b0); step();
        check("seq_wrap", 32'(bus.pc_o), 32'h000);
        drive(3'd1, 12'h020, 1'b0); step();
        drive(3'd2, 12'h300, 1'b0); step();
        check("br_nt", 32'(bus.pc_o), 32'h021);
        drive(3'd2, 12'h300, 1'b1); step();
        check("br_t", 32'(bus.pc_o), 32'h300);
        bus.instr_valid_i = 1'b0; step();
        check("hold", 32'(bus.pc_o), 32'h300);

        // Call and return
        drive(3'd1, 12'h010, 1'b0); step();
        drive(3'd3, 12'h200, 1'b0);
        check("jsb_push", {30'd0, bus.stk_push_o, bus.stk_pop_o}, 32'b10);
        check("jsb_stkpc", 32'(bus.stk_pc_o), 32'h011);
        step();
        check("jsb_pc", 32'(bus.pc_o), 32'h200);
        check("jsb_depth", 32'(bus.depth_o), 32'd1);
        drive(3'd4, 12'h000, 1'b0);
        check("ret_pop", {30'd0, bus.stk_push_o, bus.stk_pop_o}, 32'b01);
        step();
        bus.stk_pc_i = 12'h011;
        #1;
        check("ret_busy", 32'(bus.busy_o), 32'd1);
        check("ret_nopop", 32'(bus.stk_pop_o), 32'd0);
        check("ret_depth", 32'(bus.depth_o), 32'd0);
        check("ret_pc_hold", 32'(bus.pc_o), 32'h200);
        step();
        check("ret_pc", 32'(bus.pc_o), 32'h011);
        check("ret_busy0", 32'(bus.busy_o), 32'd0);

        // Return with empty stack
        drive(3'd4, 12'h000, 1'b0);
        check("unf_nopop", 32'(bus.stk_pop_o), 32'd0);
        step();
        check("unf_flag", 32'(bus.unf_o), 32'd1);
        check("unf_pc", 32'(bus.pc_o), 32'h012);
        check("unf_busy", 32'(bus.busy_o), 32'd0);

        // Interrupt entry and RETI
        drive(3'd6, 12'h000, 1'b0); step();
        check("enai", 32'(bus.int_en_o), 32'd1);
        drive(3'd1, 12'h034, 1'b0); step();
        drive(3'd3, 12'h500, 1'b0);
        bus.int_req_i = 1'b1;
        #1;
        check("int_ack", 32'(bus.int_ack_o), 32'd1);
        check("int_push", 32'(bus.stk_push_o), 32'd1);
        check("int_stkpc", 32'(bus.stk_pc_o), 32'h034);
        step();
        check("int_pc", 32'(bus.pc_o), 32'h001);
        check("int_en0", 32'(bus.int_en_o), 32'd0);
        check("int_depth", 32'(bus.depth_o), 32'd1);
        check("int_ack0", 32'(bus.int_ack_o), 32'd0);
        bus.int_req_i = 1'b0;
        drive(3'd5, 12'h000, 1'b0);
        bus.stk_pc_i = 12'h034;
        step();
        bus.int_req_i = 1'b1;
        #1;
        check("reti_defer", 32'(bus.int_ack_o), 32'd0);
        step();
        check("reti_pc", 32'(bus.pc_o), 32'h034);
        check("reti_en", 32'(bus.int_en_o), 32'd1);
        bus.instr_valid_i = 1'b0;
        #1;
        check("int_late_ack", 32'(bus.int_ack_o), 32'd1);
        step();
        bus.int_req_i = 1'b0;
        check("int_late_pc", 32'(bus.pc_o), 32'h001);
        check("int_late_dep", 32'(bus.depth_o), 32'd1);

        // Drain, then nine nested calls
        drive(3'd4, 12'h000, 1'b0); step(); step();
        check("drain_depth", 32'(bus.depth_o), 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(3'd3, 12'h100 + 12'(i), 1'b0);
            check($sformatf("nest_push%0d", i), 32'(bus.stk_push_o), 32'd1);
            step();
            if (i == 7) check("nest_ovf8", 32'(bus.ovf_o), 32'd0);
        end
        check("nest_depth", 32'(bus.depth_o), 32'd8);
        check("nest_ovf", 32'(bus.ovf_o), 32'd1);
        check("nest_pc", 32'(bus.pc_o), 32'h108);

        // Asynchronous reset in the middle of a return
        drive(3'd4, 12'h000, 1'b0); step();
        check("rw_busy", 32'(bus.busy_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", 32'(bus.pc_o), 32'h000);
        check("arst_depth", 32'(bus.depth_o), 32'd0);
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        check("arst_flags", {30'd0, bus.ovf_o, bus.unf_o}, 32'd0);
        check("arst_strb", {29'd0, bus.stk_push_o, bus.stk_pop_o, bus.int_ack_o}, 32'd0);
        drive(3'd3, 12'h100, 1'b0);
        check("arst_nopush", 32'(bus.stk_push_o), 32'd0);
        step();
        check("arst_hold", 32'(bus.pc_o), 32'h000);
        rst = 1'b0;
        bus.instr_valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
